// File: rtl/cpu_ext_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ext_loader_pkg
// Description : Shared types and constants for the cpu external-port loader.
//               State encoding of the loader FSM, memory strides and a helper
//               for 64-bit word address generation.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ext_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_I    = 3'd1,
        LD_D    = 3'd2,
        RUN     = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        RD_OUT  = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;

    // Byte address of word idx from base; idx is already zero-extended.
    function automatic logic [63:0] word_addr(input logic [63:0] base,
                                              input logic [63:0] idx,
                                              input int          stride);
        return base + idx * 64'(stride);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ext_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ext_loader_if
// Description : Bus bundle between the loader and its environment.
//               s_*       : load stream into the loader
//               m_*       : dump stream out of the loader
//               *_ext     : IMEM external port (32-bit data)
//               *_ext_2   : DMEM external port (64-bit data)
//               master    : loader side; slave : host/cpu side
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_ext_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface
`default_nettype wire

// File: rtl/cpu_ext_loader_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ext_loader_out_reg
// Description : Holding register for the dump stream.
//               clk, arst_n : clock, synchronous active-low reset
//               load        : capture load_data and raise valid
//               load_data   : DMEM read data
//               take        : downstream accepted the held word
//               valid, data : registered stream outputs; data is only
//                             overwritten by load, so it stays stable while
//                             valid is waiting for ready
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ext_loader_out_reg (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        load,
    input  logic [63:0] load_data,
    input  logic        take,
    output logic        valid,
    output logic [63:0] data
);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            valid <= 1'b0;
            data  <= 64'd0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ext_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ext_loader
// Description : Host-side initiator for the cpu external memory ports.
//               Loads IMEM then DMEM from the s_* stream, runs the core for a
//               programmed number of cycles, then dumps DMEM on the m_* stream.
//               clk, arst_n   : clock, synchronous active-low reset
//               start         : begin an operation (sampled in IDLE only)
//               imem_words,
//               dmem_words,
//               run_cycles,
//               dump_words    : phase lengths, latched on start
//               enable        : cpu run enable
//               busy, done    : status; done pulses on DONE -> IDLE
//               bus           : streams and external memory ports
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ext_loader
    import cpu_ext_loader_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [63:0] IMEM_BASE = 64'd0,
    parameter logic [63:0] DMEM_BASE = 64'd0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    output logic             enable,
    output logic             busy,
    output logic             done,
    cpu_ext_loader_if.master bus
);

    state_t           state, state_next;
    logic [CNT_W-1:0] idx, run_cnt;
    logic [CNT_W-1:0] imem_n, dmem_n, run_n, dump_n;
    logic [CNT_W-1:0] cur_imem, cur_dmem, cur_run, cur_dump, limit;
    state_t           st_from_idle, st_after_ld_i, st_after_ld_d, st_after_run;
    logic             idx_last, run_last, beat, take, load_out;

    // In IDLE the counts are being latched this very cycle, so the skip
    // chain must look at the live inputs rather than the stale registers.
    assign cur_imem = (state == IDLE) ? imem_words : imem_n;
    assign cur_dmem = (state == IDLE) ? dmem_words : dmem_n;
    assign cur_run  = (state == IDLE) ? run_cycles : run_n;
    assign cur_dump = (state == IDLE) ? dump_words : dump_n;

    // Zero-count phases are skipped in the same cycle they would be entered.
    assign st_after_run  = (cur_dump != '0) ? RD_REQ : DONE;
    assign st_after_ld_d = (cur_run  != '0) ? RUN    : st_after_run;
    assign st_after_ld_i = (cur_dmem != '0) ? LD_D   : st_after_ld_d;
    assign st_from_idle  = (cur_imem != '0) ? LD_I   : st_after_ld_i;

    assign limit    = (state == LD_I) ? imem_n : (state == LD_D) ? dmem_n : dump_n;
    assign idx_last = (idx + CNT_W'(1)) == limit;
    assign run_last = (run_cnt + CNT_W'(1)) == run_n;

    assign beat = bus.s_valid && bus.s_ready;
    assign take = (state == RD_OUT) && bus.m_valid && bus.m_ready;

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign bus.ren_ext = 1'b0;

    always_comb begin
        state_next      = state;
        enable          = 1'b0;
        load_out        = 1'b0;
        bus.s_ready     = 1'b0;
        bus.wen_ext     = 1'b0;
        bus.addr_ext    = 64'd0;
        bus.wdata_ext   = 32'd0;
        bus.wen_ext_2   = 1'b0;
        bus.ren_ext_2   = 1'b0;
        bus.addr_ext_2  = 64'd0;
        bus.wdata_ext_2 = 64'd0;
        case (state)
            IDLE: begin
                if (start) state_next = st_from_idle;
            end
            LD_I: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    bus.wen_ext   = 1'b1;
                    bus.addr_ext  = word_addr(IMEM_BASE, 64'(idx), IMEM_STRIDE);
                    bus.wdata_ext = bus.s_data[31:0];
                    if (idx_last) state_next = st_after_ld_i;
                end
            end
            LD_D: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    bus.wen_ext_2   = 1'b1;
                    bus.addr_ext_2  = word_addr(DMEM_BASE, 64'(idx), DMEM_STRIDE);
                    bus.wdata_ext_2 = bus.s_data;
                    if (idx_last) state_next = st_after_ld_d;
                end
            end
            RUN: begin
                enable = 1'b1;
                if (run_last) state_next = st_after_run;
            end
            RD_REQ: begin
                bus.ren_ext_2  = 1'b1;
                bus.addr_ext_2 = word_addr(DMEM_BASE, 64'(idx), DMEM_STRIDE);
                state_next     = RD_WAIT;
            end
            RD_WAIT: begin
                load_out   = 1'b1;
                state_next = RD_OUT;
            end
            RD_OUT: begin
                if (take) state_next = idx_last ? DONE : RD_REQ;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A reset held low blocks memory strobes in the cycle it is asserted,
        // so an abort never lets one more word slip into memory.
        if (!arst_n) begin
            bus.s_ready   = 1'b0;
            bus.wen_ext   = 1'b0;
            bus.wen_ext_2 = 1'b0;
            bus.ren_ext_2 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state   <= IDLE;
            idx     <= '0;
            run_cnt <= '0;
            imem_n  <= '0;
            dmem_n  <= '0;
            run_n   <= '0;
            dump_n  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                imem_n <= imem_words;
                dmem_n <= dmem_words;
                run_n  <= run_cycles;
                dump_n <= dump_words;
            end
            // idx returns to 0 on the last beat of each phase, so every
            // phase is entered with a cleared index.
            case (state)
                LD_I, LD_D: if (beat) idx <= idx_last ? '0 : idx + CNT_W'(1);
                RD_OUT:     if (take) idx <= idx_last ? '0 : idx + CNT_W'(1);
                IDLE:       idx <= '0;
                default:    idx <= idx;
            endcase
            if (state == RUN) run_cnt <= run_last ? '0 : run_cnt + CNT_W'(1);
            else              run_cnt <= '0;
        end
    end

    cpu_ext_loader_out_reg u_out_reg (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (load_out),
        .load_data (bus.rdata_ext_2),
        .take      (take),
        .valid     (bus.m_valid),
        .data      (bus.m_data)
    );

endmodule
`default_nettype wire
